// File: rtl/alu_control_unit_if.sv
// Decoder bus between the main control unit and the ALU control decoder.
interface alu_control_unit_if;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] alu_ctrl;
  logic       illegal;

  modport master (output ALUOp, output funct3, output funct7,
                  input  alu_ctrl, input illegal);
  modport slave  (input  ALUOp, input funct3, input funct7,
                  output alu_ctrl, output illegal);
endinterface

// File: rtl/alu_control_unit.sv
// RV32I ALU control decoder: ALUOp + funct3/funct7 -> registered 4-bit ALU op
// code and illegal-encoding flag, one clock of latency.
module alu_control_unit (
  input  logic                clk,
  input  logic                rst,
  alu_control_unit_if.slave   bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [3:0] ctrl_d;
  logic       illegal_d;
  logic [3:0] base_op;

  // funct3 map shared by R-type (funct7=0) and I-type.
  always_comb begin
    base_op = OP_ADD;
    case (bus.funct3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      3'b111:  base_op = OP_AND;
      default: base_op = 'x;
    endcase
  end

  always_comb begin
    ctrl_d    = OP_ADD;
    illegal_d = 1'b0;
    case (bus.ALUOp)
      ALUOP_MEM:    ctrl_d = OP_ADD;
      ALUOP_BRANCH: ctrl_d = OP_SUB;
      ALUOP_RTYPE: begin
        if (bus.funct7 == F7_BASE) begin
          ctrl_d = base_op;
        end else if (bus.funct7 == F7_ALT && bus.funct3 == 3'b000) begin
          ctrl_d = OP_SUB;
        end else if (bus.funct7 == F7_ALT && bus.funct3 == 3'b101) begin
          ctrl_d = OP_SRA;
        end else begin
          illegal_d = 1'b1;
        end
      end
      ALUOP_ITYPE: begin
        // funct7 only qualifies the shift encodings; elsewhere it is immediate data.
        if (bus.funct3 == 3'b001) begin
          if (bus.funct7 == F7_BASE) ctrl_d = OP_SLL;
          else                       illegal_d = 1'b1;
        end else if (bus.funct3 == 3'b101) begin
          if (bus.funct7 == F7_BASE)     ctrl_d = OP_SRL;
          else if (bus.funct7 == F7_ALT) ctrl_d = OP_SRA;
          else                           illegal_d = 1'b1;
        end else begin
          ctrl_d = base_op;
        end
      end
      // Unknown ALUOp propagates rather than being masked to a legal code.
      default: begin
        ctrl_d    = 'x;
        illegal_d = 1'bx;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_ctrl <= '0;
      bus.illegal  <= 1'b0;
    end else begin
      bus.alu_ctrl <= ctrl_d;
      bus.illegal  <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit: hand-computed vectors, one task per feature.
module tb_alu_control_unit;

  logic clk;
  logic rst;
  logic clk_en;
  int   vectors;
  int   miscompares;

  alu_control_unit_if bus ();

  alu_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // Apply inputs just after an edge; result is captured on the next edge.
  task automatic apply(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.ALUOp  = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clk_en = 1'b0;
    rst    = 1'b0;
    #3;
    rst = 1'b1;
    #2;
    vectors++;
    if (bus.alu_ctrl !== 4'b0000 || bus.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got ctrl=%b ill=%b want 0000/0", bus.alu_ctrl, bus.illegal);
    end
    bus.ALUOp  = 2'b10;
    bus.funct3 = 3'b101;
    bus.funct7 = 7'b0100000;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.alu_ctrl !== 4'b0000 || bus.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: got ctrl=%b ill=%b want 0000/0", bus.alu_ctrl, bus.illegal);
    end
    rst = 1'b0;
  endtask

  task automatic test_mem_branch;
    apply(2'b00, 3'bxxx, 7'bxxxxxxx);
    vectors++;
    if (bus.alu_ctrl !== 4'b0000 || bus.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL aluop00_add: got ctrl=%b ill=%b want 0000/0", bus.alu_ctrl, bus.illegal);
    end
    apply(2'b01, 3'bxxx, 7'bxxxxxxx);
    vectors++;
    if (bus.alu_ctrl !== 4'b0001 || bus.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL aluop01_sub: got ctrl=%b ill=%b want 0001/0", bus.alu_ctrl, bus.illegal);
    end
  endtask

  task automatic test_latency;
    // Change input just before the edge result settles: output must lag by one edge.
    bus.ALUOp  = 2'b10;
    bus.funct3 = 3'b100;
    bus.funct7 = 7'b0000000;
    #1;
    vectors++;
    if (bus.alu_ctrl !== 4'b0001) begin
      miscompares++;
      $display("FAIL latency_hold: got ctrl=%b want 0001", bus.alu_ctrl);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.alu_ctrl !== 4'b0100) begin
      miscompares++;
      $display("FAIL latency_update: got ctrl=%b want 0100", bus.alu_ctrl);
    end
  endtask

  task automatic test_rtype_alt;
    logic [1:0] op [4] = '{2'b10, 2'b10, 2'b10, 2'b10};
    logic [2:0] f3 [4] = '{3'b000, 3'b000, 3'b101, 3'b101};
    logic [6:0] f7 [4] = '{7'b0000000, 7'b0100000, 7'b0100000, 7'b0000000};
    logic [3:0] ex [4] = '{4'b0000, 4'b0001, 4'b0111, 4'b0110};
    for (int i = 0; i < 4; i++) begin
      apply(op[i], f3[i], f7[i]);
      vectors++;
      if (bus.alu_ctrl !== ex[i] || bus.illegal !== 1'b0) begin
        miscompares++;
        $display("FAIL rtype_alt[%0d]: got ctrl=%b ill=%b want %b/0", i, bus.alu_ctrl, bus.illegal, ex[i]);
      end
    end
  endtask

  task automatic test_rtype_sweep;
    logic [3:0] ex [8] = '{4'b0000, 4'b0101, 4'b1000, 4'b1001,
                           4'b0100, 4'b0110, 4'b0011, 4'b0010};
    for (int i = 0; i < 8; i++) begin
      apply(2'b10, 3'(i), 7'b0000000);
      vectors++;
      if (bus.alu_ctrl !== ex[i] || bus.illegal !== 1'b0) begin
        miscompares++;
        $display("FAIL rtype_sweep[f3=%0d]: got ctrl=%b ill=%b want %b/0", i, bus.alu_ctrl, bus.illegal, ex[i]);
      end
    end
  endtask

  task automatic test_illegal;
    logic [1:0] op [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [2:0] f3 [5] = '{3'b111, 3'b000, 3'b010, 3'b001, 3'b101};
    logic [6:0] f7 [5] = '{7'b0100000, 7'b0000001, 7'b0100000, 7'b0100000, 7'b0000001};
    for (int i = 0; i < 5; i++) begin
      apply(op[i], f3[i], f7[i]);
      vectors++;
      if (bus.alu_ctrl !== 4'b0000 || bus.illegal !== 1'b1) begin
        miscompares++;
        $display("FAIL illegal[%0d]: got ctrl=%b ill=%b want 0000/1", i, bus.alu_ctrl, bus.illegal);
      end
    end
    // Legal decode right after an illegal one must clear the flag.
    apply(2'b10, 3'b110, 7'b0000000);
    vectors++;
    if (bus.alu_ctrl !== 4'b0011 || bus.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_clear: got ctrl=%b ill=%b want 0011/0", bus.alu_ctrl, bus.illegal);
    end
  endtask

  task automatic test_itype;
    logic [2:0] f3 [6] = '{3'b000, 3'b101, 3'b101, 3'b001, 3'b111, 3'b010};
    logic [6:0] f7 [6] = '{7'b0100000, 7'b0100000, 7'b0000000, 7'b0000000, 7'b1111111, 7'b0100000};
    logic [3:0] ex [6] = '{4'b0000, 4'b0111, 4'b0110, 4'b0101, 4'b0010, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      apply(2'b11, f3[i], f7[i]);
      vectors++;
      if (bus.alu_ctrl !== ex[i] || bus.illegal !== 1'b0) begin
        miscompares++;
        $display("FAIL itype[%0d]: got ctrl=%b ill=%b want %b/0", i, bus.alu_ctrl, bus.illegal, ex[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    apply(2'b11, 3'b101, 7'b0100000);
    vectors++;
    if (bus.alu_ctrl !== 4'b0111) begin
      miscompares++;
      $display("FAIL pre_reset_sra: got ctrl=%b want 0111", bus.alu_ctrl);
    end
    apply(2'b10, 3'b111, 7'b0100000);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.alu_ctrl !== 4'b0000 || bus.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got ctrl=%b ill=%b want 0000/0", bus.alu_ctrl, bus.illegal);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(2'b01, 3'b000, 7'b0000000);
    vectors++;
    if (bus.alu_ctrl !== 4'b0001 || bus.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: got ctrl=%b ill=%b want 0001/0", bus.alu_ctrl, bus.illegal);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk_en      = 1'b0;
    rst         = 1'b0;
    bus.ALUOp   = 2'b00;
    bus.funct3  = 3'b000;
    bus.funct7  = 7'b0000000;
    test_reset();
    test_mem_branch();
    test_latency();
    test_rtype_alt();
    test_rtype_sweep();
    test_illegal();
    test_itype();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
